// File: rtl/axi_burst_master_if.sv
// AXI-style burst bus between axi_burst_master and a slave: AR/R read and AW/W/B write channels.
interface axi_burst_master_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned RESP_W = 2
) ();

  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [LEN_W-1:0]  ARLEN;
  logic [ID_W-1:0]   ARID;

  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic [RESP_W-1:0] RRESP;
  logic              RLAST;
  logic [ID_W-1:0]   RID;

  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [LEN_W-1:0]  AWLEN;
  logic [ID_W-1:0]   AWID;

  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic              WLAST;

  logic              BVALID;
  logic              BREADY;
  logic [RESP_W-1:0] BRESP;
  logic [ID_W-1:0]   BID;

  modport master (
    output ARVALID, ARADDR, ARLEN, ARID,
    input  ARREADY,
    input  RVALID, RDATA, RRESP, RLAST, RID,
    output RREADY,
    output AWVALID, AWADDR, AWLEN, AWID,
    input  AWREADY,
    output WVALID, WDATA, WLAST,
    input  WREADY,
    input  BVALID, BRESP, BID,
    output BREADY
  );

  modport slave (
    input  ARVALID, ARADDR, ARLEN, ARID,
    output ARREADY,
    output RVALID, RDATA, RRESP, RLAST, RID,
    input  RREADY,
    input  AWVALID, AWADDR, AWLEN, AWID,
    output AWREADY,
    input  WVALID, WDATA, WLAST,
    output WREADY,
    output BVALID, BRESP, BID,
    input  BREADY
  );

endinterface

// File: rtl/axi_burst_master.sv
// Burst AXI master: independent read (AR/R) and write (AW/W/B) engines driven by a simple
// start/done command interface, with beat counting, WLAST generation and per-burst error flags.
module axi_burst_master #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned LEN_W  = 4,
  parameter int unsigned RESP_W = 2
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [ID_W-1:0]   rd_id,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_valid,
  output logic              rd_busy,
  output logic              rd_done,
  output logic              rd_err,

  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [ID_W-1:0]   wr_id,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_valid,
  output logic              wr_data_ready,
  output logic              wr_busy,
  output logic              wr_done,
  output logic              wr_err,

  axi_burst_master_if.master axi
);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [LEN_W:0] CntOne = (LEN_W+1)'(1);

  // ---------------------------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------------------------
  logic [1:0]        r_state_q, r_state_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [LEN_W-1:0]  r_len_q, r_len_d;
  logic [ID_W-1:0]   r_id_q, r_id_d;
  logic [LEN_W:0]    r_cnt_q, r_cnt_d;
  logic              r_err_acc_q, r_err_acc_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_data_valid_q, rd_data_valid_d;
  logic              rd_done_q, rd_done_d;
  logic              rd_err_q, rd_err_d;
  logic              r_last;
  logic              r_beat_err;

  // Burst length is authoritative; RLAST only feeds the error check.
  assign r_last     = (r_cnt_q == {1'b0, r_len_q});
  assign r_beat_err = (axi.RRESP != '0) || (axi.RID != r_id_q) || (axi.RLAST != r_last);

  always_comb begin
    r_state_d       = r_state_q;
    r_addr_d        = r_addr_q;
    r_len_d         = r_len_q;
    r_id_d          = r_id_q;
    r_cnt_d         = r_cnt_q;
    r_err_acc_d     = r_err_acc_q;
    rd_data_d       = rd_data_q;
    rd_data_valid_d = 1'b0;
    rd_done_d       = 1'b0;
    rd_err_d        = rd_err_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (rd_start) begin
          r_addr_d    = rd_addr;
          r_len_d     = rd_len;
          r_id_d      = rd_id;
          r_cnt_d     = '0;
          r_err_acc_d = 1'b0;
          rd_err_d    = 1'b0;
          r_state_d   = R_ADDR;
        end
      end
      R_ADDR: begin
        if (axi.ARREADY) r_state_d = R_DATA;
      end
      R_DATA: begin
        if (axi.RVALID) begin
          rd_data_d       = axi.RDATA;
          rd_data_valid_d = 1'b1;
          r_cnt_d         = r_cnt_q + CntOne;
          r_err_acc_d     = r_err_acc_q | r_beat_err;
          if (r_last) begin
            rd_done_d = 1'b1;
            rd_err_d  = r_err_acc_q | r_beat_err;
            r_state_d = R_IDLE;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q       <= R_IDLE;
      r_addr_q        <= '0;
      r_len_q         <= '0;
      r_id_q          <= '0;
      r_cnt_q         <= '0;
      r_err_acc_q     <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
      rd_done_q       <= 1'b0;
      rd_err_q        <= 1'b0;
    end else begin
      r_state_q       <= r_state_d;
      r_addr_q        <= r_addr_d;
      r_len_q         <= r_len_d;
      r_id_q          <= r_id_d;
      r_cnt_q         <= r_cnt_d;
      r_err_acc_q     <= r_err_acc_d;
      rd_data_q       <= rd_data_d;
      rd_data_valid_q <= rd_data_valid_d;
      rd_done_q       <= rd_done_d;
      rd_err_q        <= rd_err_d;
    end
  end

  assign axi.ARVALID   = (r_state_q == R_ADDR);
  assign axi.ARADDR    = r_addr_q;
  assign axi.ARLEN     = r_len_q;
  assign axi.ARID      = r_id_q;
  assign axi.RREADY    = (r_state_q == R_DATA);
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign rd_busy       = (r_state_q != R_IDLE);
  assign rd_done       = rd_done_q;
  assign rd_err        = rd_err_q;

  // ---------------------------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------------------------
  logic [1:0]        w_state_q, w_state_d;
  logic [ADDR_W-1:0] w_addr_q, w_addr_d;
  logic [LEN_W-1:0]  w_len_q, w_len_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [LEN_W:0]    w_loaded_q, w_loaded_d;
  logic              wvalid_q, wvalid_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wlast_q, wlast_d;
  logic              wr_done_q, wr_done_d;
  logic              wr_err_q, wr_err_d;
  logic              w_load;
  logic              w_hs;

  // The output stage can take a new beat when empty or draining this cycle.
  assign wr_data_ready = (w_state_q == W_DATA) && (w_loaded_q <= {1'b0, w_len_q}) &&
                         (!wvalid_q || axi.WREADY);
  assign w_load        = wr_data_valid && wr_data_ready;
  assign w_hs          = wvalid_q && axi.WREADY;

  always_comb begin
    w_state_d  = w_state_q;
    w_addr_d   = w_addr_q;
    w_len_d    = w_len_q;
    w_id_d     = w_id_q;
    w_loaded_d = w_loaded_q;
    wvalid_d   = wvalid_q;
    wdata_d    = wdata_q;
    wlast_d    = wlast_q;
    wr_done_d  = 1'b0;
    wr_err_d   = wr_err_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (wr_start) begin
          w_addr_d   = wr_addr;
          w_len_d    = wr_len;
          w_id_d     = wr_id;
          w_loaded_d = '0;
          wr_err_d   = 1'b0;
          w_state_d  = W_ADDR;
        end
      end
      W_ADDR: begin
        if (axi.AWREADY) w_state_d = W_DATA;
      end
      W_DATA: begin
        if (w_load) begin
          wvalid_d   = 1'b1;
          wdata_d    = wr_data;
          wlast_d    = (w_loaded_q == {1'b0, w_len_q});
          w_loaded_d = w_loaded_q + CntOne;
        end else if (w_hs) begin
          wvalid_d = 1'b0;
          wlast_d  = 1'b0;
        end
        if (w_hs && wlast_q) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (axi.BVALID) begin
          wr_done_d = 1'b1;
          wr_err_d  = (axi.BRESP != '0) || (axi.BID != w_id_q);
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q  <= W_IDLE;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_id_q     <= '0;
      w_loaded_q <= '0;
      wvalid_q   <= 1'b0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      w_state_q  <= w_state_d;
      w_addr_q   <= w_addr_d;
      w_len_q    <= w_len_d;
      w_id_q     <= w_id_d;
      w_loaded_q <= w_loaded_d;
      wvalid_q   <= wvalid_d;
      wdata_q    <= wdata_d;
      wlast_q    <= wlast_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  assign axi.AWVALID = (w_state_q == W_ADDR);
  assign axi.AWADDR  = w_addr_q;
  assign axi.AWLEN   = w_len_q;
  assign axi.AWID    = w_id_q;
  assign axi.WVALID  = wvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WLAST   = wlast_q;
  assign axi.BREADY  = (w_state_q == W_RESP);
  assign wr_busy     = (w_state_q != W_IDLE);
  assign wr_done     = wr_done_q;
  assign wr_err      = wr_err_q;

endmodule

// File: doc/axi_burst_master.md
# axi_burst_master

Parametrised successor to the team's fixed-width AXI master: drives independent burst-read (AR/R) and burst-write (AW/W/B) channels from a simple user command interface. It adds parametrised address, data, ID and length widths, beat counting with WLAST generation, RLAST/ID checking and per-burst error reporting. It sits between user/test logic and an AXI-style slave in the EE454 interconnect.

## Interface
- ADDR_W, 8, address width
- DATA_W, 8, data beat width
- ID_W, 4, transaction ID width
- LEN_W, 4, burst length field width (beats = LEN+1)
- RESP_W, 2, response width (0 = OKAY, nonzero = error)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rd_start  in  1  request read burst (honoured only when rd_busy=0)
- rd_addr / rd_len / rd_id  in  ADDR_W / LEN_W / ID_W  read command, sampled with rd_start
- rd_data  out  DATA_W  captured read beat
- rd_data_valid  out  1  one-cycle strobe per captured beat
- rd_busy / rd_done / rd_err  out  1  read status; done is a 1-cycle pulse, err valid with done
- wr_start  in  1  request write burst (honoured only when wr_busy=0)
- wr_addr / wr_len / wr_id  in  ADDR_W / LEN_W / ID_W  write command, sampled with wr_start
- wr_data  in  DATA_W  user write beat
- wr_data_valid  in  1  user beat available
- wr_data_ready  out  1  combinational; beat taken when valid & ready
- wr_busy / wr_done / wr_err  out  1  write status, same pulse rules as read
- ARVALID out 1, ARREADY in 1, ARADDR out ADDR_W, ARLEN out LEN_W, ARID out ID_W
- RVALID in 1, RREADY out 1, RDATA in DATA_W, RRESP in RESP_W, RLAST in 1, RID in ID_W
- AWVALID out 1, AWREADY in 1, AWADDR out ADDR_W, AWLEN out LEN_W, AWID out ID_W
- WVALID out 1, WREADY in 1, WDATA out DATA_W, WLAST out 1
- BVALID in 1, BREADY out 1, BRESP in RESP_W, BID in ID_W

## Operation
- Read and write engines independent; may run concurrently. Start while busy ignored.
- Read FSM: R_IDLE -> (rd_start) R_ADDR -> (ARVALID&ARREADY) R_DATA -> (last beat accepted) R_IDLE.
- R_ADDR: ARVALID=1, ARADDR/ARLEN/ARID held stable from latched command until handshake.
- R_DATA: RREADY=1; each RVALID&RREADY captures RDATA into rd_data, increments beat counter (LEN_W+1 bits).
- Read burst ends at beat count = len+1 regardless of RLAST. rd_err set (sticky for burst) if any RRESP≠0, RID≠latched id, RLAST=1 before final beat, or RLAST=0 on final beat.
- Write FSM: W_IDLE -> (wr_start) W_ADDR -> (AWVALID&AWREADY) W_DATA -> (last beat handshaked on W) W_RESP -> (BVALID&BREADY) W_IDLE.
- W_DATA: registered WVALID/WDATA/WLAST output stage. wr_data_ready = in W_DATA & beats_loaded < len+1 & (!WVALID | WREADY). Loaded beat sets WVALID=1; WLAST=1 exactly on beat len+1. WVALID drops after W handshake with no new beat.
- W_RESP: BREADY=1. wr_err = BRESP≠0 or BID≠latched id.
- ARLEN/AWLEN carry len unchanged; no address incrementing (slave computes burst addresses).

## Timing
- Reset: every output 0; both FSMs to IDLE; counters and error flags cleared. Reset mid-burst abandons transfer immediately, no done pulse.
- rd_start at edge N -> ARVALID=1 from N+1. ARREADY high at edge M -> ARVALID=0, RREADY=1 from M+1.
- Beat accepted at edge K -> rd_data/rd_data_valid=1 during K+1 only.
- Final read beat at edge K -> rd_done=1, rd_err valid, rd_busy=0, RREADY=0 during K+1; new rd_start accepted at K+1.
- Write: AW handshake at edge M -> wr_data_ready may assert from M+1; beat taken at edge P -> WVALID=1 from P+1. Full throughput one beat/cycle with WREADY held high.
- Final W handshake at edge Q -> BREADY=1 from Q+1; B handshake at edge S -> wr_done=1, wr_busy=0 during S+1.
- busy asserts the cycle after start is accepted and stays high through done cycle's preceding edge.
- WVALID never deasserts without WREADY (AXI stability); ARVALID/AWVALID likewise.

## Test plan
- Read len=3, addr=0x40, id=5, slave ARREADY after 2 cycles, beats 0xA1..0xA4 back-to-back, RLAST on 4th -> 4 rd_data_valid strobes with A1..A4, rd_done with rd_err=0.
- Read len=2 with RLAST on beat 2 (early) or RRESP=2 on beat 1 or RID=6 -> exactly 3 beats consumed, rd_done with rd_err=1.
- Write len=3, addr=0x80, id=3, data 0x11..0x14, WREADY toggling 1,0,1,0 -> WDATA stable while WVALID&!WREADY, WLAST only with 0x14, BRESP=0 -> wr_done, wr_err=0.
- Write len=0 with BRESP=2 -> single beat with WLAST=1, wr_done with wr_err=1; BID≠id also sets wr_err.
- Concurrent read len=7 and write len=7 started same cycle -> both complete, counts correct, no cross-channel interference; rd_start during rd_busy ignored.
- Assert rst mid read R_DATA and mid write W_DATA -> next cycle all outputs 0, busy=0, no done pulse; fresh bursts then complete normally.
